baudrate_generator_frac: RTL and testbench
==========================================

// Module: baudrate_generator_frac
// PURPOSE
//  Runtime-programmable fractional baud tick generator for the UART TX/RX paths.
//  Emits an oversample tick (o_os_tick) at average period DIV_INT + DIV_FRAC/2^NB_FRAC clocks,
//  plus a bit tick (o_bit_tick) every OVERSAMPLE oversample ticks.
//  Supports divisor reload without glitches, enable gating and phase resync for RX start-bit alignment.
// PARAMETERS
//  CLK_FREQ    50000000  input clock frequency, Hz
//  BAUD_RATE   19200     reset-time baud rate; sets the default divisor
//  OVERSAMPLE  16        oversample ticks per bit tick, >=2
//  NB_DIV      16        width of the integer divisor
//  NB_FRAC     4         width of the fractional divisor
//  Default divisor DEF = round(CLK_FREQ*2^NB_FRAC/(BAUD_RATE*OVERSAMPLE)).
//  DEF_INT = DEF>>NB_FRAC and DEF_FRAC = DEF[NB_FRAC-1:0]. Defaults give 2604, so INT=162 and FRAC=12.
// PORTS
//  i_clock          in   1        system clock, rising edge
//  i_reset          in   1        asynchronous reset, active-low
//  i_enable         in   1        1 = run; 0 = hold in idle
//  i_sync           in   1        1-cycle pulse; restarts tick phase
//  i_load           in   1        1-cycle pulse; captures i_div_int and i_div_frac
//  i_div_int        in   NB_DIV   requested integer divisor; values <2 are clamped to 2
//  i_div_frac       in   NB_FRAC  requested fractional divisor
//  o_os_tick        out  1        oversample tick, 1 cycle wide, registered
//  o_bit_tick       out  1        bit tick, 1 cycle wide, coincident with an o_os_tick
//  o_div_int        out  NB_DIV   divisor currently in use (active)
//  o_div_frac       out  NB_FRAC  fractional divisor currently in use (active)
//  o_load_pending   out  1        shadow divisor captured but not yet applied
// BEHAVIOUR
//  Reset (i_reset=0, async):
//   - active and shadow divisors = DEF_INT/DEF_FRAC; cnt = DEF_INT-1; acc = 0; os_cnt = 0
//   - all tick outputs and o_load_pending = 0
//  Disabled (i_enable=0):
//   - cnt = D-1, acc = 0, os_cnt = 0, ticks = 0. D is the active integer divisor.
//   - a pending load is applied at once.
//  Enabled, per clock:
//   - cnt != 0: cnt decrements
//   - cnt == 0: o_os_tick <= 1 for the next cycle; {carry, acc} <= acc + F
//   - on reload, cnt <= D-1+carry, so the period is D or D+1
//   - first tick after enable occurs D edges after the first enabled edge
//  Average period: D + F/2^NB_FRAC clocks. With D=162 and F=12, the period sequence is 162,163,163,163 and repeats.
//  Bit tick: os_cnt counts o_os_tick events 0..OVERSAMPLE-1. o_bit_tick = 1 in the same cycle as the
//   o_os_tick that wraps os_cnt from OVERSAMPLE-1 to 0.
//  Load:
//   - i_load latches (max(i_div_int,2), i_div_frac) into the shadow and sets o_load_pending
//   - the shadow is copied to active at the next reload (cnt==0 edge); that reload already uses the new D/F
//   - o_load_pending clears on that same edge
//   - a second i_load before the apply overwrites the shadow (last write wins)
//  Sync (i_sync=1, enabled):
//   - cnt = D-1, acc = 0, os_cnt = 0; any tick that would fire on that edge is suppressed
//   - next o_os_tick follows D edges later
//   - i_sync and i_load on the same edge: new divisor is applied immediately, and cnt = Dnew-1
//   - i_sync with pending load: pending load is applied on the sync edge
//  Arithmetic: cnt is NB_DIV+1 bits wide, so D+1 never overflows; acc wraps modulo 2^NB_FRAC.
//  Reset mid-operation: immediate return to reset values; no partial tick is emitted.
// TESTING
//  1. Defaults, enable held 1 -> first o_os_tick 162 edges after enable; next intervals 162,163,163,163;
//     every 4 ticks span exactly 651 clocks.
//  2. Defaults, run 32 bit ticks -> o_bit_tick interval exactly 2604 clocks; every bit tick coincides with os tick.
//  3. Load INT=651,FRAC=0 mid-period -> o_load_pending=1 until the next reload; then intervals = 651 with no
//     short or long glitch period; o_div_int=651.
//  4. i_div_int=0 or 1 loaded -> o_div_int=2; ticks every 2 clocks with FRAC=0.
//  5. i_sync pulsed 50 clocks into a period and on a would-be tick edge -> that tick suppressed;
//     next tick exactly D edges after the sync edge; os_cnt restarts, so a bit tick comes 16 os ticks later.
//  6. Async reset asserted mid-period, between clock edges -> outputs 0 immediately; after release, behaves as test 1.

Source files
------------

// File: rtl/baudrate_generator_frac_if.sv
// baudrate_generator_frac_if: control and status bundle of the fractional baud tick generator.
interface baudrate_generator_frac_if #(
  parameter int NB_DIV  = 16,
  parameter int NB_FRAC = 4
);
  logic               i_enable;
  logic               i_sync;
  logic               i_load;
  logic [NB_DIV-1:0]  i_div_int;
  logic [NB_FRAC-1:0] i_div_frac;
  logic               o_os_tick;
  logic               o_bit_tick;
  logic [NB_DIV-1:0]  o_div_int;
  logic [NB_FRAC-1:0] o_div_frac;
  logic               o_load_pending;
  modport master (
    output i_enable, i_sync, i_load, i_div_int, i_div_frac,
    input  o_os_tick, o_bit_tick, o_div_int, o_div_frac, o_load_pending
  );
  modport slave (
    input  i_enable, i_sync, i_load, i_div_int, i_div_frac,
    output o_os_tick, o_bit_tick, o_div_int, o_div_frac, o_load_pending
  );
endinterface

// File: rtl/baudrate_generator_frac.sv
// baudrate_generator_frac: fractional-N oversample/bit tick generator with shadowed divisor reload and phase resync.
module baudrate_generator_frac #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 19200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int          NB_DIV     = 16,
  parameter int          NB_FRAC    = 4
) (
  input logic i_clock,
  input logic i_reset,
  baudrate_generator_frac_if.slave bus
);
  localparam int CW   = NB_DIV + 1;
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam longint unsigned BDIV = 64'(BAUD_RATE) * 64'(OVERSAMPLE);
  localparam longint unsigned DEF  = (64'(CLK_FREQ) * (64'd1 << NB_FRAC) + BDIV / 2) / BDIV;
  localparam logic [NB_DIV-1:0]  DEF_INT  = NB_DIV'(DEF >> NB_FRAC);
  localparam logic [NB_FRAC-1:0] DEF_FRAC = NB_FRAC'(DEF);
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NB_FRAC-1:0] acc_q, acc_d;
  logic [OS_W-1:0]    os_cnt_q, os_cnt_d;
  logic [NB_DIV-1:0]  act_int_q, act_int_d, sh_int_q, sh_int_d;
  logic [NB_FRAC-1:0] act_frac_q, act_frac_d, sh_frac_q, sh_frac_d;
  logic               pend_q, pend_d, os_tick_q, os_tick_d, bit_tick_q, bit_tick_d;
  logic [NB_DIV-1:0]  new_int, d_use;
  logic [NB_FRAC-1:0] f_use;
  logic [NB_FRAC:0]   sum;
  logic               pend_n, restart, reload, apply, wrap;
  always_comb begin
    new_int    = (bus.i_div_int < NB_DIV'(2)) ? NB_DIV'(2) : bus.i_div_int;
    sh_int_d   = bus.i_load ? new_int : sh_int_q;
    sh_frac_d  = bus.i_load ? bus.i_div_frac : sh_frac_q;
    pend_n     = bus.i_load | pend_q;
    restart    = !bus.i_enable | bus.i_sync;
    reload     = !restart & (cnt_q == '0);
    // the shadow only moves to active on a period boundary, so no period is ever cut short or stretched
    apply      = pend_n & (restart | reload);
    d_use      = apply ? sh_int_d : act_int_q;
    f_use      = apply ? sh_frac_d : act_frac_q;
    sum        = {1'b0, acc_q} + {1'b0, f_use};
    wrap       = os_cnt_q == OS_W'(OVERSAMPLE - 1);
    act_int_d  = d_use;
    act_frac_d = f_use;
    pend_d     = pend_n & !apply;
    cnt_d      = restart ? CW'(d_use) - CW'(1) :
                 reload  ? CW'(d_use) - CW'(1) + CW'(sum[NB_FRAC]) : cnt_q - CW'(1);
    acc_d      = restart ? '0 : reload ? sum[NB_FRAC-1:0] : acc_q;
    os_cnt_d   = restart ? '0 : reload ? (wrap ? '0 : os_cnt_q + OS_W'(1)) : os_cnt_q;
    os_tick_d  = reload;
    bit_tick_d = reload & wrap;
  end
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q      <= CW'(DEF_INT) - CW'(1);
      acc_q      <= '0;
      os_cnt_q   <= '0;
      act_int_q  <= DEF_INT;
      act_frac_q <= DEF_FRAC;
      sh_int_q   <= DEF_INT;
      sh_frac_q  <= DEF_FRAC;
      pend_q     <= 1'b0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      os_cnt_q   <= os_cnt_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      sh_int_q   <= sh_int_d;
      sh_frac_q  <= sh_frac_d;
      pend_q     <= pend_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
    end
  end
  assign bus.o_os_tick      = os_tick_q;
  assign bus.o_bit_tick     = bit_tick_q;
  assign bus.o_div_int      = act_int_q;
  assign bus.o_div_frac     = act_frac_q;
  assign bus.o_load_pending = pend_q;
endmodule

// File: tb/tb_baudrate_generator_frac.sv
// tb_baudrate_generator_frac: directed vectors and hand-written corner sequences for the fractional baud generator.
module tb_baudrate_generator_frac;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int coinc_bad = 0;
  always #5 clk = ~clk;
  baudrate_generator_frac_if #(.NB_DIV(16), .NB_FRAC(4)) bus ();
  baudrate_generator_frac dut (.i_clock(clk), .i_reset(rst_n), .bus(bus));
  typedef struct {
    logic [15:0] di;
    logic [3:0]  df;
    int          eint;
    int          efrac;
    int          p [5];
  } vec_t;
  vec_t v [7];
  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic wait_tick(input string name, output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.o_os_tick && n < 5000);
    if (!bus.o_os_tick) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no os tick within %0d clocks", name, n);
    end
  endtask
  task automatic wait_bit(input string name, output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.o_bit_tick && n < 10000);
    if (!bus.o_bit_tick) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no bit tick within %0d clocks", name, n);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (bus.o_bit_tick && !bus.o_os_tick) coinc_bad++;
  end
  initial begin
    int n;
    v[0] = '{16'd0,   4'd0,  2,   0,  '{2, 2, 2, 2, 2}};
    v[1] = '{16'd1,   4'd0,  2,   0,  '{2, 2, 2, 2, 2}};
    v[2] = '{16'd2,   4'd8,  2,   8,  '{2, 2, 3, 2, 3}};
    v[3] = '{16'd5,   4'd4,  5,   4,  '{5, 5, 5, 5, 6}};
    v[4] = '{16'd162, 4'd12, 162, 12, '{162, 162, 163, 163, 163}};
    v[5] = '{16'd651, 4'd0,  651, 0,  '{651, 651, 651, 651, 651}};
    v[6] = '{16'd3,   4'd15, 3,   15, '{3, 3, 4, 4, 4}};
    bus.i_enable = 1'b0; bus.i_sync = 1'b0; bus.i_load = 1'b0;
    bus.i_div_int = '0; bus.i_div_frac = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_os_tick", bus.o_os_tick, 0);
    chk("rst_bit_tick", bus.o_bit_tick, 0);
    chk("rst_div_int", bus.o_div_int, 162);
    chk("rst_div_frac", bus.o_div_frac, 12);
    chk("rst_pending", bus.o_load_pending, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    bus.i_enable = 1'b1;
    // bit ticks from defaults: 16 os ticks = 162 + 3*651 + 162+163+163
    wait_bit("bit_first", n);    chk("bit_first", n, 2603);
    wait_bit("bit_int1", n);     chk("bit_int1", n, 2604);
    wait_bit("bit_int2", n);     chk("bit_int2", n, 2604);
    repeat (50) @(posedge clk);
    #1;
    bus.i_load = 1'b1; bus.i_div_int = 16'd651; bus.i_div_frac = 4'd0;
    @(posedge clk); #1;
    bus.i_load = 1'b0;
    chk("ld_pending_set", bus.o_load_pending, 1);
    chk("ld_old_div", bus.o_div_int, 162);
    wait_tick("ld_rest", n);     chk("ld_rest", n, 112);
    chk("ld_pending_clr", bus.o_load_pending, 0);
    chk("ld_new_div", bus.o_div_int, 651);
    wait_tick("ld_int1", n);     chk("ld_int1", n, 651);
    wait_tick("ld_int2", n);     chk("ld_int2", n, 651);
    bus.i_load = 1'b1; bus.i_div_int = 16'd10;
    @(posedge clk); #1;
    bus.i_div_int = 16'd4;
    @(posedge clk); #1;
    bus.i_load = 1'b0;
    chk("lww_pending", bus.o_load_pending, 1);
    wait_tick("lww_rest", n);    chk("lww_rest", n, 649);
    chk("lww_div", bus.o_div_int, 4);
    wait_tick("lww_int", n);     chk("lww_int", n, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_os_tick", bus.o_os_tick, 0);
    chk("arst_div_int", bus.o_div_int, 162);
    chk("arst_div_frac", bus.o_div_frac, 12);
    #3 rst_n = 1'b1;
    wait_tick("arst_first", n);  chk("arst_first", n, 162);
    wait_tick("arst_int1", n);   chk("arst_int1", n, 162);
    wait_tick("arst_int2", n);   chk("arst_int2", n, 163);
    repeat (49) @(posedge clk);
    #1 bus.i_sync = 1'b1;
    @(posedge clk); #1;
    bus.i_sync = 1'b0;
    wait_tick("sync_mid", n);    chk("sync_mid", n, 162);
    repeat (161) @(posedge clk);
    #1 bus.i_sync = 1'b1;
    @(posedge clk); #1;
    bus.i_sync = 1'b0;
    chk("sync_suppress", bus.o_os_tick, 0);
    wait_tick("sync_edge", n);   chk("sync_edge", n, 162);
    wait_bit("sync_bit", n);     chk("sync_bit", n, 2441);
    bus.i_sync = 1'b1; bus.i_load = 1'b1; bus.i_div_int = 16'd5; bus.i_div_frac = 4'd0;
    @(posedge clk); #1;
    bus.i_sync = 1'b0; bus.i_load = 1'b0;
    chk("syld_div", bus.o_div_int, 5);
    chk("syld_pending", bus.o_load_pending, 0);
    wait_tick("syld_first", n);  chk("syld_first", n, 5);
    wait_tick("syld_int", n);    chk("syld_int", n, 5);
    for (int i = 0; i < 7; i++) begin
      bus.i_enable = 1'b0; bus.i_load = 1'b1;
      bus.i_div_int = v[i].di; bus.i_div_frac = v[i].df;
      @(posedge clk); #1;
      bus.i_load = 1'b0;
      chk($sformatf("vec%0d_div_int", i), bus.o_div_int, v[i].eint);
      chk($sformatf("vec%0d_div_frac", i), bus.o_div_frac, v[i].efrac);
      chk($sformatf("vec%0d_pending", i), bus.o_load_pending, 0);
      @(posedge clk); #1;
      bus.i_enable = 1'b1;
      for (int k = 0; k < 5; k++) begin
        wait_tick($sformatf("vec%0d_p%0d", i, k), n);
        chk($sformatf("vec%0d_p%0d", i, k), n, v[i].p[k]);
      end
    end
    chk("bit_os_coincide", coinc_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
